// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU instruction sequencer: opcode encodings,
// the 20-bit instruction word layout and the sequencer state encoding.
package alu_seq_pkg;

    localparam int WORD_W = 20;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    // Field order fixes the word layout: [19] save, [18:16] opcode, [15:8] a, [7:0] b.
    typedef struct packed {
        logic       save;
        logic [2:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Operand/result bundle between the sequencer (master) and the ALU datapath (slave).
interface alu_instr_sequencer_if;

    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opcode;
    logic       save;
    logic [7:0] alu_out;
    logic       carry_out;

    modport master (
        output a,
        output b,
        output opcode,
        output save,
        input  alu_out,
        input  carry_out
    );

    modport slave (
        input  a,
        input  b,
        input  opcode,
        input  save,
        output alu_out,
        output carry_out
    );

endinterface

// File: rtl/alu_seq_prog_mem.sv
// Program store for the sequencer: PROG_DEPTH instruction words, synchronous
// write that is blocked while a run is in progress, and a registered read.
module alu_seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              busy_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  instr_t            wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output instr_t            rdata_o
);

    instr_t mem_q [PROG_DEPTH];
    instr_t rdata_q;

    // Accept host writes only while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (we_i && !busy_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; a write and a read of the same address in one cycle
    // returns the old word, so a fetch one cycle after the write sees new data.
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/alu_instr_sequencer.sv
// Clocked instruction sequencer that plays a stored program into the ALU
// datapath and reports each result. Optional macro ALU_SEQ_CHECKSUM_EN adds
// a 9-bit rotate/XOR checksum over all captured {carry, result} pairs.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PROG_DEPTH  = 16,
    parameter int ADDR_W      = $clog2(PROG_DEPTH),
    parameter int ALU_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W:0]        prog_len,
    input  logic                   prog_we,
    input  logic [ADDR_W-1:0]      prog_addr,
    input  logic [WORD_W-1:0]      prog_wdata,
    alu_instr_sequencer_if.master  dp,
    output logic [7:0]             result,
    output logic                   result_carry,
    output logic                   result_valid,
    output logic [ADDR_W-1:0]      pc,
    output logic                   busy,
    output logic                   done
`ifdef ALU_SEQ_CHECKSUM_EN
    ,
    output logic [8:0]             checksum
`endif
);

    localparam logic [2:0]    LAT_L   = 3'(ALU_LATENCY);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(PROG_DEPTH);

    seq_state_e        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              save_q, save_d;
    logic [7:0]        result_q, result_d;
    logic              rcarry_q, rcarry_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;
`ifdef ALU_SEQ_CHECKSUM_EN
    logic [8:0]        csum_q, csum_d;
`endif

    instr_t            fetched;
    logic [ADDR_W:0]   len_clamped;
    logic              last_instr;
    logic              busy_w;

    assign busy_w      = (state_q != ST_IDLE);
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_instr  = (({1'b0, pc_q} + 1'b1) == len_q);

    alu_seq_prog_mem #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (prog_we),
        .busy_i  (busy_w),
        .waddr_i (prog_addr),
        .wdata_i (instr_t'(prog_wdata)),
        .raddr_i (pc_q),
        .rdata_o (fetched)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (prog_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH:   state_d = ST_ISSUE;
            ST_ISSUE:   state_d = (LAT_L == 3'd0) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = last_instr ? ST_DONE : ST_FETCH;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Per-state next values of the operand, result and bookkeeping registers.
    always_comb begin
        len_d    = len_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        save_d   = save_q;
        result_d = result_q;
        rcarry_d = rcarry_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
`ifdef ALU_SEQ_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d  = len_clamped;
                    pc_d   = '0;
`ifdef ALU_SEQ_CHECKSUM_EN
                    csum_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                a_d    = fetched.a;
                b_d    = fetched.b;
                op_d   = fetched.opcode;
                save_d = fetched.save;
                cnt_d  = LAT_L;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
            end
            ST_CAPTURE: begin
                result_d = dp.alu_out;
                rcarry_d = dp.carry_out;
                rvalid_d = 1'b1;
                save_d   = 1'b0;
                if (!last_instr) begin
                    pc_d = pc_q + 1'b1;
                end
`ifdef ALU_SEQ_CHECKSUM_EN
                csum_d = {csum_q[7:0], csum_q[8]} ^ {dp.carry_out, dp.alu_out};
`endif
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers; reset zeroes every visible output.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            save_q   <= 1'b0;
            result_q <= '0;
            rcarry_q <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            len_q    <= len_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            save_q   <= save_d;
            result_q <= result_d;
            rcarry_q <= rcarry_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign dp.a         = a_q;
    assign dp.b         = b_q;
    assign dp.opcode    = op_q;
    assign dp.save      = save_q;
    assign result       = result_q;
    assign result_carry = rcarry_q;
    assign result_valid = rvalid_q;
    assign pc           = pc_q;
    assign busy         = busy_w;
    assign done         = done_q;
`ifdef ALU_SEQ_CHECKSUM_EN
    assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer with a latency-1 ALU model.
// Checksum checks are included when ALU_SEQ_CHECKSUM_EN is defined.
module tb_alu_instr_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [19:0]   prog_wdata = '0;
    logic [7:0]    result;
    logic          result_carry, result_valid, busy, done;
    logic [AW-1:0] pc;
`ifdef ALU_SEQ_CHECKSUM_EN
    logic [8:0]    checksum;
`endif

    alu_instr_sequencer_if dp_if ();

    alu_instr_sequencer #(.PROG_DEPTH(DEPTH), .ALU_LATENCY(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_len     (prog_len),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata),
        .dp           (dp_if),
        .result       (result),
        .result_carry (result_carry),
        .result_valid (result_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
`ifdef ALU_SEQ_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: bit 8 is carry (ADD) or borrow (SUB).
    function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_MUL:  r = {1'b0, 8'(a * b)};
            OP_DIV:  r = (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
            OP_CMP:  r = {a < b, 7'd0, a == b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // One-cycle-latency datapath driven from the sequencer's operands.
    always @(posedge clk) begin
        {dp_if.carry_out, dp_if.alu_out} <= alu_model(dp_if.opcode, dp_if.a, dp_if.b);
    end

    function automatic logic [19:0] mkw(input logic s, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        return {s, op, a, b};
    endfunction

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int rv_cnt = 0;
    int save_cyc = 0;
    int save_rise = 0;
    logic save_prev = 1'b0;
    int start_cyc = 0;
    int done_cyc = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every result_valid and tracks pulses.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (dp_if.save) save_cyc++;
        if (dp_if.save && !save_prev) save_rise++;
        save_prev = dp_if.save;
        if (result_valid) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got 0x%0h, expected no result", {result_carry, result});
            end else begin
                check("result", {23'd0, result_carry, result}, {23'd0, exp_q.pop_front()});
            end
            check("save_clear_at_capture", {31'd0, dp_if.save}, 32'd0);
        end
    end

    task automatic write_word(input int addr, input logic [19:0] w);
        prog_we    = 1'b1;
        prog_addr  = AW'(addr);
        prog_wdata = w;
        @(negedge clk);
        prog_we    = 1'b0;
    endtask

    task automatic start_run(input int len);
        prog_len = (AW + 1)'(len);
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    int rv0, dn0;

    initial begin
        @(negedge clk);
        @(negedge clk);
        // Reset state
        check("rst_a", dp_if.a, 0);
        check("rst_b", dp_if.b, 0);
        check("rst_opcode", dp_if.opcode, 0);
        check("rst_save", dp_if.save, 0);
        check("rst_result", {result_carry, result}, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word program: ADD then SUB, 9 cycles start to done
        write_word(0, mkw(1'b0, OP_ADD, 8'h05, 8'h03));
        write_word(1, mkw(1'b1, OP_SUB, 8'hCC, 8'hAA));
        exp_q.push_back(9'h008);
        exp_q.push_back(9'h022);
        rv0 = rv_cnt; dn0 = done_cnt;
        start_run(2);
        wait_done("t1", 40);
        check("t1_latency", done_cyc - start_cyc, 9);
        settle();
        check("t1_results", rv_cnt - rv0, 2);
        check("t1_done_pulses", done_cnt - dn0, 1);
        check("t1_busy_after", busy, 0);
`ifdef ALU_SEQ_CHECKSUM_EN
        check("t1_checksum", checksum, 9'h032);
`endif

        // Logic ops with save on words 0 and 2 only
        write_word(0, mkw(1'b1, OP_AND, 8'h05, 8'h03));
        write_word(1, mkw(1'b0, OP_OR,  8'hCC, 8'hAA));
        write_word(2, mkw(1'b1, OP_XOR, 8'h05, 8'h03));
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h0EE);
        exp_q.push_back(9'h006);
        save_cyc = 0; save_rise = 0;
        start_run(3);
        wait_done("t2", 60);
        check("t2_latency", done_cyc - start_cyc, 13);
        settle();
        check("t2_save_cycles", save_cyc, 4);
        check("t2_save_windows", save_rise, 2);
        check("t2_pc_last", pc, 2);

        // Empty program: done next cycle, operands untouched
        rv0 = rv_cnt;
        start_run(0);
        wait_done("t3", 10);
        check("t3_latency", done_cyc - start_cyc, 1);
        settle();
        check("t3_no_result", rv_cnt - rv0, 0);
        check("t3_a_hold", dp_if.a, 8'h05);
        check("t3_b_hold", dp_if.b, 8'h03);
        check("t3_op_hold", dp_if.opcode, OP_XOR);
`ifdef ALU_SEQ_CHECKSUM_EN
        check("t3_checksum_cleared", checksum, 0);
`endif

        // Reset during WAIT of word 1
        exp_q.push_back(9'h001);
        rv0 = rv_cnt; dn0 = done_cnt;
        start_run(3);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_a", dp_if.a, 0);
        check("t4_b", dp_if.b, 0);
        check("t4_opcode", dp_if.opcode, 0);
        check("t4_save", dp_if.save, 0);
        check("t4_result", {result_carry, result}, 0);
        check("t4_result_valid", result_valid, 0);
        check("t4_pc", pc, 0);
        check("t4_busy", busy, 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("t4_no_done", done_cnt - dn0, 0);
        check("t4_one_result", rv_cnt - rv0, 1);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h0EE);
        exp_q.push_back(9'h006);
        start_run(3);
        wait_done("t4_rerun", 60);
        check("t4_rerun_latency", done_cyc - start_cyc, 13);
        settle();

        // Write and start while busy are both dropped
        exp_q.push_back(9'h001);
        start_run(1);
        prog_we = 1'b1; prog_addr = '0; prog_wdata = mkw(1'b0, OP_ADD, 8'hFF, 8'hFF);
        start = 1'b1; prog_len = 5'd3;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_done("t5", 20);
        check("t5_latency", done_cyc - start_cyc, 5);
        settle();
        exp_q.push_back(9'h001);
        start_run(1);
        wait_done("t5_rerun", 20);
        settle();

        // Write and start in the same idle cycle: fetch sees the new word
        exp_q.push_back(9'h100);
        prog_we = 1'b1; prog_addr = '0; prog_wdata = mkw(1'b0, OP_ADD, 8'h80, 8'h80);
        start = 1'b1; prog_len = 5'd1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        start_cyc = cyc;
        wait_done("t6", 20);
        check("t6_latency", done_cyc - start_cyc, 5);
        settle();

        // Full depth with oversize prog_len: clamped, pc ends at 15
        for (int i = 0; i < DEPTH; i++) begin
            write_word(i, mkw(1'b0, OP_ADD, 8'(i), 8'h01));
            exp_q.push_back(9'(i + 1));
        end
        start_run(17);
        wait_done("t7", 120);
        check("t7_latency", done_cyc - start_cyc, 65);
        settle();
        check("t7_pc_end", pc, 15);
        check("t7_busy", busy, 0);
        check("t7_scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
